// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// MUL_SIGNED_EN adds the FIXUP state used for signed-result correction.
package mul_share_pkg;

  localparam int MUL_W = 32;
  localparam int PW    = 2 * MUL_W;
  localparam int CNT_W = 4;

  typedef logic owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
`ifdef MUL_SIGNED_EN
    ,
    ST_FIXUP  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/mul_share_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser after each grant.
module rr_arb2
  import mul_share_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output owner_t     grant_id
);

  owner_t rr_q, rr_d;

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: begin
        grant    = 2'b10;
        grant_id = 1'b1;
      end
      2'b11: begin
        grant    = rr_q ? 2'b10 : 2'b01;
        grant_id = rr_q;
      end
      default: ;
    endcase
    rr_d = rr_q;
    if (advance && (grant != 2'b00)) rr_d = ~grant_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one combinational multiplier between two requesters (IDLE -> SETTLE -> RESP).
// Define MUL_SIGNED_EN to support signed operations via an extra FIXUP cycle.
//
// Handshakes: a request transfers on a cycle with req_valid[i] & req_ready[i]; a
// result transfers on a cycle with rsp_valid[i] & rsp_ready[i]. Valid, once raised,
// is held with stable data until the transfer.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int WIDTH  = MUL_W,
  parameter int SETTLE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  input  logic [1:0]           req_sgn,
  output logic [WIDTH-1:0]     mul_x,
  output logic [WIDTH-1:0]     mul_y,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 busy
);

  localparam int PW_L = 2 * WIDTH;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [PW_L-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]       grant;
  owner_t           grant_id;
  logic             idle;
  logic [WIDTH-1:0] sel_a, sel_b;

  assign idle  = (state_q == ST_IDLE);
  assign sel_a = grant_id ? req_a1 : req_a0;
  assign sel_b = grant_id ? req_b1 : req_b0;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (idle),
    .grant    (grant),
    .grant_id (grant_id)
  );

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;
  logic sel_sgn;

  assign sel_sgn = req_sgn[grant_id];

  // Most negative value negates to itself, which reads correctly as unsigned 2^(W-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction
`else
  logic unused_sgn;
  assign unused_sgn = ^req_sgn;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    mul_x_d    = mul_x_q;
    mul_y_d    = mul_y_q;
    rsp_data_d = rsp_data_q;
`ifdef MUL_SIGNED_EN
    neg_d      = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant_id;
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = ST_SETTLE;
`ifdef MUL_SIGNED_EN
          mul_x_d = mag(sel_a, sel_sgn);
          mul_y_d = mag(sel_b, sel_sgn);
          neg_d   = sel_sgn & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
`else
          mul_x_d = sel_a;
          mul_y_d = sel_b;
`endif
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_data_d = mul_p;
`ifdef MUL_SIGNED_EN
          state_d    = ST_FIXUP;
`else
          state_d    = ST_RESP;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef MUL_SIGNED_EN
      ST_FIXUP: begin
        if (neg_q) rsp_data_d = ~rsp_data_q + 1'b1;
        state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      mul_x_q    <= '0;
      mul_y_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      mul_x_q    <= mul_x_d;
      mul_y_q    <= mul_y_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef MUL_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end
`endif

  assign req_ready = idle ? grant : 2'b00;
  assign rsp_valid = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl against a cycle-level transaction model.
// Build with MUL_SIGNED_EN defined to exercise the signed path.
module tb_mul_share_ctrl;

  localparam int S = 3;
`ifdef MUL_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, req_sgn, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, mul_x, mul_y;
  logic [63:0] mul_p, rsp_data;
  logic        busy;

  // stand-in for the shared combinational multiplier
  assign mul_p = {32'b0, mul_x} * {32'b0, mul_y};

  mul_share_ctrl #(.WIDTH(32), .SETTLE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_sgn   (req_sgn),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // scoreboard and transaction model state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        grant_log[$];
  int          m_phase;   // 0 free, 1 computing, 2 result offered
  int          m_wait;
  logic        m_rr;
  logic        m_owner;
  logic [63:0] obs_data;
  logic [63:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
`ifdef MUL_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) return 64'(sa * sb);
`endif
    return {32'b0, a} * {32'b0, b};
  endfunction

  // one clock of stimulus plus model-based checking of the combinational view
  task automatic cyc(input logic [1:0] v, input logic [1:0] rr_in, input logic [1:0] sg,
                     input logic [31:0] a0, input logic [31:0] b0,
                     input logic [31:0] a1, input logic [31:0] b1);
    logic [1:0] g;
    logic [1:0] rv;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr_in;
    req_sgn   = sg;
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    #1;
    g = 2'b00;
    if (m_phase == 0) begin
      if (v == 2'b01)      g = 2'b01;
      else if (v == 2'b10) g = 2'b10;
      else if (v == 2'b11) g = m_rr ? 2'b10 : 2'b01;
    end
    rv = (m_phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", {62'b0, req_ready}, {62'b0, g});
    check("rsp_valid", {62'b0, rsp_valid}, {62'b0, rv});
    check("busy", {63'b0, busy}, {63'b0, (m_phase != 0)});
    obs_data = rsp_data;
    if (m_phase == 2) check("rsp_data", rsp_data, exp_q[0]);
    if (m_phase == 0 && g != 2'b00) begin
      m_owner = g[1];
      m_rr    = ~g[1];
      grant_log.push_back(g[1]);
      exp_q.push_back(g[1] ? ref_prod(a1, b1, sg[1]) : ref_prod(a0, b0, sg[0]));
      m_wait  = S + EXTRA;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_wait--;
      if (m_wait == 0) m_phase = 2;
    end else if (m_phase == 2 && rr_in[m_owner]) begin
      void'(exp_q.pop_front());
      m_phase = 0;
    end
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] rr_in);
    for (int i = 0; i < n; i++) cyc(2'b00, rr_in, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", {62'b0, rsp_valid}, 64'h0);
    check("rst_req_ready", {62'b0, req_ready}, 64'h0);
    check("rst_busy", {63'b0, busy}, 64'h0);
    check("rst_mul_x", {32'b0, mul_x}, 64'h0);
    check("rst_mul_y", {32'b0, mul_y}, 64'h0);
    check("rst_rsp_data", rsp_data, 64'h0);
    m_phase = 0;
    m_rr    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00; req_sgn = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    m_phase = 0; m_wait = 0; m_rr = 1'b0; m_owner = 1'b0;
    #3;
    check("por_rsp_valid", {62'b0, rsp_valid}, 64'h0);
    check("por_busy", {63'b0, busy}, 64'h0);
    check("por_rsp_data", rsp_data, 64'h0);
    check("por_mul_x", {32'b0, mul_x}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request: 7*6, response exactly S+1 (+1 signed) cycles after the accept cycle
    cyc(2'b01, 2'b00, 2'b00, 32'd7, 32'd6, 32'h0, 32'h0);
    idle_cycles(S + EXTRA, 2'b00);
    cyc(2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("single_42", obs_data, 64'd42);

    // full-scale operands on requester 1
    cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_cycles(S + EXTRA, 2'b00);
    cyc(2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("max_prod", obs_data, 64'hFFFF_FFFE_0000_0001);

    // backpressure with both requesting; non-owner rsp_ready must be ignored
    cyc(2'b01, 2'b00, 2'b00, 32'd1234, 32'd5678, 32'h0, 32'h0);
    idle_cycles(S + EXTRA, 2'b00);
    held = 64'd1234 * 64'd5678;
    for (int i = 0; i < 10; i++) begin
      cyc(2'b11, 2'b10, 2'b00, 32'd9, 32'd9, 32'd3, 32'd4);
      check("bp_stable", obs_data, held);
    end
    cyc(2'b11, 2'b01, 2'b00, 32'd9, 32'd9, 32'd3, 32'd4);
    cyc(2'b11, 2'b00, 2'b00, 32'd9, 32'd9, 32'd3, 32'd4);
    idle_cycles(S + EXTRA + 1, 2'b11);

    // reset while computing: no response may follow, next op completes
    cyc(2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'd11, 32'd13);
    idle_cycles(1, 2'b11);
    do_reset();
    idle_cycles(S + EXTRA + 3, 2'b11);
    cyc(2'b01, 2'b00, 2'b00, 32'd100, 32'd200, 32'h0, 32'h0);
    idle_cycles(S + EXTRA, 2'b00);
    cyc(2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("post_rst_prod", obs_data, 64'd20000);

`ifdef MUL_SIGNED_EN
    cyc(2'b01, 2'b00, 2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0);
    idle_cycles(S + EXTRA, 2'b00);
    cyc(2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("signed_m15", obs_data, 64'hFFFF_FFFF_FFFF_FFF1);
`endif

    // contention from reset: grants must alternate 0,1,0,1
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 4 * (S + EXTRA + 2); i++)
      cyc(2'b11, 2'b11, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
    check("cont_ngrants", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("cont_order", {63'b0, grant_log[k]}, 64'(k % 2));

    // randomized traffic with random valid drops and random result backpressure
    for (int i = 0; i < 400; i++)
      cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
          ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom, $urandom);
    idle_cycles(S + EXTRA + 2, 2'b11);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
